// File: rtl/sisc_fetch.sv
// SISC instruction fetch: PC, single-outstanding memory read, ir handshake.
// Optional HALTED state for opcode 4'hF enabled by SISC_FETCH_HALT_EN.
module sisc_fetch #(
   parameter int ADDR_W   = 16,
   parameter int RESET_PC = 0,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst_f,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              stall,
   output logic [31:0]       ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);

`ifdef SISC_FETCH_HALT_EN
   typedef enum logic [1:0] {S_REQ, S_DELIV, S_ERR, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_REQ, S_DELIV, S_ERR} state_t;
`endif

   state_t            state, state_n;
   logic              squash, squash_n;
   logic [CW-1:0]     wcnt, wcnt_n;
   logic              req_n, valid_n, err_n;
   logic [ADDR_W-1:0] addr_n, pc_n;
   logic [31:0]       ir_n;

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state     <= S_REQ;
         pc        <= ADDR_W'(RESET_PC);
         mem_addr  <= ADDR_W'(RESET_PC);
         mem_req   <= 1'b0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         fetch_err <= 1'b0;
         squash    <= 1'b0;
         wcnt      <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         mem_addr  <= addr_n;
         mem_req   <= req_n;
         ir        <= ir_n;
         ir_valid  <= valid_n;
         fetch_err <= err_n;
         squash    <= squash_n;
         wcnt      <= wcnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      addr_n   = mem_addr;
      req_n    = mem_req;
      ir_n     = ir;
      valid_n  = ir_valid;
      err_n    = fetch_err;
      squash_n = squash;
      wcnt_n   = wcnt;
      unique case (state)
         S_REQ: begin
            if (!mem_req) begin
               // a redirect seen before launch simply launches at the target
               if (br_taken) begin
                  pc_n   = br_target;
                  addr_n = br_target;
               end else begin
                  addr_n = pc;
               end
               req_n  = 1'b1;
               wcnt_n = '0;
            end else if (mem_ack) begin
               req_n    = 1'b0;
               wcnt_n   = '0;
               squash_n = 1'b0;
               if (br_taken) begin
                  pc_n = br_target;
               end else if (!squash) begin
                  ir_n    = mem_rdata;
                  valid_n = 1'b1;
                  pc_n    = pc + ADDR_W'(1);
                  state_n = S_DELIV;
               end
            end else if (wcnt == CW'(MAX_WAIT - 1)) begin
               req_n   = 1'b0;
               err_n   = 1'b1;
               state_n = S_ERR;
            end else begin
               wcnt_n = wcnt + CW'(1);
               if (br_taken) begin
                  pc_n     = br_target;
                  squash_n = 1'b1;
               end
            end
         end
         S_DELIV: begin
            if (br_taken) begin
               valid_n = 1'b0;
               pc_n    = br_target;
               state_n = S_REQ;
            end else if (!stall) begin
               valid_n = 1'b0;
               state_n = S_REQ;
`ifdef SISC_FETCH_HALT_EN
               if (ir[31:28] == 4'hF)
                  state_n = S_HALT;
`endif
            end
         end
         S_ERR: begin
            req_n   = 1'b0;
            valid_n = 1'b0;
            err_n   = 1'b1;
         end
`ifdef SISC_FETCH_HALT_EN
         S_HALT: begin
            req_n   = 1'b0;
            valid_n = 1'b0;
         end
`endif
         default: begin
            req_n   = 1'b0;
            valid_n = 1'b0;
            err_n   = 1'b1;
            state_n = S_ERR;
         end
      endcase
   end

endmodule
